// File: rtl/xnor_correlator.sv
// xnor_correlator
//   Two-stage pipelined bitwise-XNOR correlator. Each accepted sample yields
//   the per-bit XNOR vector, its popcount and a threshold hit flag, two
//   cycles after it is presented. No backpressure: one sample per cycle.
//
//   Optional feature macro: XNOR_CORR_STATS_EN
//     defined   -> 16-bit saturating hit_total counter with synchronous clear
//     undefined -> no counter flops, hit_total tied to 0, clear ignored
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (flushes both stages)
//   in_valid   qualifies A/B this cycle
//   A, B       WIDTH-bit operands
//   clear      synchronous clear of hit_total only
//   Y          registered XNOR of A and B
//   match_cnt  number of ones in Y (CW = $clog2(WIDTH+1) bits)
//   out_valid  Y / match_cnt / hit valid this cycle
//   hit        match_cnt >= THRESH, qualified by out_valid
//   hit_total  saturating count of hit pulses
module xnor_correlator #(
    parameter  int WIDTH  = 8,
    parameter  int THRESH = WIDTH,
    localparam int CW     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clear,
    output logic [WIDTH-1:0] Y,
    output logic [CW-1:0]    match_cnt,
    output logic             out_valid,
    output logic             hit,
    output logic [15:0]      hit_total
);

    localparam int          STAGES   = 2;
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    // Unsigned sum of all bits; CW bits always hold WIDTH, so no overflow.
    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < WIDTH; i++) s = s + CW'(v[i]);
        return s;
    endfunction

    // vld_pipe[1] is the stage-1 valid, vld_pipe[STAGES] drives out_valid.
    logic [STAGES:1]   vld_pipe;
    logic [WIDTH-1:0]  s1_y;
    logic [CW-1:0]     s1_cnt;

    assign s1_cnt = popcount(s1_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            s1_y      <= '0;
            Y         <= '0;
            match_cnt <= '0;
            hit       <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            // Stage 1 only captures qualified samples; otherwise holds.
            if (in_valid) s1_y <= ~(A ^ B);
            // Stage 2 reloads every edge; Y/match_cnt are don't-care
            // while out_valid is low, hit is forced low by the valid term.
            Y         <= s1_y;
            match_cnt <= s1_cnt;
            hit       <= vld_pipe[1] && (s1_cnt >= THRESH_C);
        end
    end

    assign out_valid = vld_pipe[STAGES];

`ifdef XNOR_CORR_STATS_EN
    logic [15:0] total_q;

    // clear beats a same-cycle hit; saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst || clear)                      total_q <= '0;
        else if (hit && (total_q != 16'hFFFF)) total_q <= total_q + 16'd1;
    end

    assign hit_total = total_q;
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign hit_total    = 16'h0000;
`endif

endmodule

// File: tb/tb_xnor_correlator.sv
module tb_xnor_correlator;

`ifdef XNOR_CORR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b1;
    logic [7:0] a = 8'hFF, b = 8'hFF;
    logic       clear = 1'b0;

    logic [7:0]  y8, y4;
    logic [3:0]  cnt8, cnt4;
    logic        ov8, ov4, hit8, hit4;
    logic [15:0] tot8, tot4;

    always #5 clk = ~clk;

    xnor_correlator #(.WIDTH(8), .THRESH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .clear(clear),
        .Y(y8), .match_cnt(cnt8), .out_valid(ov8), .hit(hit8), .hit_total(tot8));

    xnor_correlator #(.WIDTH(8), .THRESH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .clear(clear),
        .Y(y4), .match_cnt(cnt4), .out_valid(ov4), .hit(hit4), .hit_total(tot4));

    typedef struct {
        int         due;
        logic [7:0] y;
        logic [3:0] cnt;
        logic       h8;
        logic       h4;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    logic [15:0] exp_tot8 = 16'h0, exp_tot4 = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] next_tot(input logic [15:0] t, input logic h);
        if (!STATS || rst || clear) return 16'h0;
        if (h && t != 16'hFFFF)     return t + 16'd1;
        return t;
    endfunction

    // Output monitor: anything not scheduled for this cycle must be invalid.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            logic eh8, eh4;
            eh8 = 1'b0;
            eh4 = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("out_valid8", 64'(ov8), 64'(1'b1));
                chk("out_valid4", 64'(ov4), 64'(1'b1));
                chk("y8",         64'(y8),  64'(e.y));
                chk("y4",         64'(y4),  64'(e.y));
                chk("cnt8",       64'(cnt8), 64'(e.cnt));
                chk("cnt4",       64'(cnt4), 64'(e.cnt));
                chk("hit8",       64'(hit8), 64'(e.h8));
                chk("hit4",       64'(hit4), 64'(e.h4));
                eh8 = e.h8;
                eh4 = e.h4;
            end else begin
                chk("idle_valid8", 64'(ov8),  64'(1'b0));
                chk("idle_valid4", 64'(ov4),  64'(1'b0));
                chk("idle_hit8",   64'(hit8), 64'(1'b0));
                chk("idle_hit4",   64'(hit4), 64'(1'b0));
            end
            chk("hit_total8", 64'(tot8), 64'(exp_tot8));
            chk("hit_total4", 64'(tot4), 64'(exp_tot4));
            exp_tot8 = next_tot(exp_tot8, eh8);
            exp_tot4 = next_tot(exp_tot4, eh4);
        end
    end

    // One cycle of stimulus, applied just after a rising edge.
    task automatic step(input logic v, input logic [7:0] ai, input logic [7:0] bi,
                        input logic r = 1'b0, input logic c = 1'b0);
        exp_t e;
        in_valid = v;
        a        = ai;
        b        = bi;
        rst      = r;
        clear    = c;
        if (r) begin
            // Reset edge discards everything not already on the outputs.
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
        end else if (v) begin
            e.due = cyc + 2;
            e.y   = ~(ai ^ bi);
            e.cnt = 4'($countones(e.y));
            e.h8  = (e.cnt >= 4'd8);
            e.h4  = (e.cnt >= 4'd4);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held with a matching valid sample on the inputs.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'hFF, 8'hFF, 1'b1);
            chk("rst_y8",   64'(y8),   64'(8'h00));
            chk("rst_cnt8", 64'(cnt8), 64'(4'd0));
            chk("rst_y4",   64'(y4),   64'(8'h00));
            chk("rst_cnt4", 64'(cnt4), 64'(4'd0));
        end

        // Truth table and back-to-back latency.
        step(1'b1, 8'hA5, 8'hA5);
        step(1'b1, 8'h00, 8'hFF);
        step(1'b1, 8'hF0, 8'hFF);
        idle(3);

        // Threshold edges around 4.
        step(1'b1, 8'h0F, 8'h00);
        step(1'b1, 8'h07, 8'h00);
        step(1'b1, 8'h1F, 8'h00);
        idle(3);

        // Gap in the input stream.
        step(1'b1, 8'h33, 8'h33);
        step(1'b0, 8'hFF, 8'h00);
        step(1'b1, 8'h3C, 8'hC3);
        idle(3);

        // Reset while two samples are in flight.
        step(1'b1, 8'h11, 8'h11);
        step(1'b1, 8'h22, 8'h22, 1'b1);
        idle(4);

        // Five hits counted from a fresh reset.
        step(1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h55, 8'h55);
        idle(4);
        chk("five_hits8", 64'(tot8), STATS ? 64'd5 : 64'd0);
        chk("five_hits4", 64'(tot4), STATS ? 64'd5 : 64'd0);

        // clear lands in the cycle the hit is visible.
        step(1'b1, 8'hAA, 8'hAA);
        step(1'b0, 8'h00, 8'h00);
        chk("pre_clear_hit8", 64'(hit8), 64'(1'b1));
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("clear_wins8", 64'(tot8), 64'd0);
        chk("clear_wins4", 64'(tot4), 64'd0);
        idle(2);

        // Saturation.
        step(1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 70000; i++) step(1'b1, 8'hFF, 8'hFF);
        idle(4);
        chk("sat8", 64'(tot8), STATS ? 64'hFFFF : 64'd0);
        chk("sat4", 64'(tot4), STATS ? 64'hFFFF : 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xnor_correlator.md
# xnor_correlator

Parametrised, pipelined bitwise-XNOR correlator. It compares two WIDTH-bit words per accepted sample and produces the per-bit XNOR vector, the count of matching bits, and a threshold hit flag. An optional saturating counter tallies hits across a run. It is the registered, multi-bit successor of the single-bit gate-level XNOR and sits in datapath compare/pattern-match paths.

## Interface
Parameters:
- WIDTH, 8: compared word width in bits; legal range 1 to 64.
- THRESH, WIDTH: minimum match count that asserts hit. Legal range is 0 to WIDTH; 0 makes every valid output a hit.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies A and B in the current cycle.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- clear  input  1  synchronous clear of hit_total; has no effect on the pipeline.
- Y  output  WIDTH  registered bitwise XNOR of A and B.
- match_cnt  output  CW  number of 1 bits in Y, where CW = $clog2(WIDTH+1).
- out_valid  output  1  Y, match_cnt and hit are valid this cycle.
- hit  output  1  match_cnt >= THRESH, qualified by out_valid.
- hit_total  output  16  saturating count of hit pulses; 0 when the feature is compiled out.

## Operation
- Stage 1 (on an edge with in_valid=1):
  - s1_y <= ~(A ^ B)
  - s1_v <= 1
  - When in_valid=0, s1_v <= 0 and s1_y holds its value.
- Stage 2 (every edge):
  - Y <= s1_y
  - match_cnt <= popcount(s1_y)
  - hit <= s1_v && (popcount(s1_y) >= THRESH)
  - out_valid <= s1_v
- Y and match_cnt hold their last values while out_valid=0. Consumers must ignore them in that state.
- The block has no backpressure. It accepts one sample per cycle, unconditionally.
- Popcount is a pure adder tree, unsigned, CW bits wide. It cannot overflow, since the maximum value is WIDTH.
- The threshold compare is unsigned and at full CW width.
- hit_total (feature enabled), priority highest first:
  - rst: set to 0.
  - clear: set to 0, even if hit=1 in the same cycle.
  - hit=1 and hit_total < 16'hFFFF: increment by 1.
  - Otherwise: hold. The counter saturates at 16'hFFFF and never wraps.
- hit_total increments on the cycle after hit is registered high. Its value reflects hits up to and including the previous cycle.

## Timing
- Reset values, applied on the first rising edge with rst=1:
  - Y = 0, match_cnt = 0, out_valid = 0, hit = 0, hit_total = 0
  - s1_y = 0, s1_v = 0
- Latency is 2 cycles: a sample presented with in_valid=1 at edge N appears with out_valid=1 after edge N+1.
- Throughput is 1 sample per cycle. Back-to-back valid samples emerge back to back, in order, with no gaps.
- Asserting rst mid-stream flushes both stages. out_valid is 0 starting the cycle after the reset edge, and in-flight samples are discarded.
- The first sample accepted after rst deasserts obeys the normal 2-cycle latency.
- clear and in_valid are independent. clear never drops or delays pipeline data.
- No combinational path exists from any input to any output.

## Configuration
- XNOR_CORR_STATS_EN defined:
  - The 16-bit hit_total counter and its clear logic are compiled in, behaving as described above.
- XNOR_CORR_STATS_EN undefined:
  - No counter flops are built.
  - hit_total is tied to 16'h0000 and clear is ignored.
  - Y, match_cnt, hit and out_valid behave identically to the enabled build.

## Test plan
- Reset check (WIDTH=8, THRESH=8): hold rst=1 for 2 cycles with in_valid=1 and A=B=8'hFF.
  - Required: Y=0, match_cnt=0, out_valid=0, hit=0, hit_total=0 throughout.
- Truth table and latency (WIDTH=8): stream A/B = 8'hA5/8'hA5, 8'h00/8'hFF, 8'hF0/8'hFF on 3 consecutive cycles.
  - Required outputs, two cycles after each sample and consecutive: Y=8'hFF/cnt=8/hit=1, then Y=8'h00/cnt=0/hit=0, then Y=8'hF0/cnt=4/hit=0.
- Threshold edges (WIDTH=8, THRESH=4):
  - A=8'h0F, B=8'h00 -> cnt=4, hit=1.
  - A=8'h07, B=8'h00 -> cnt=5, hit=1.
  - A=8'h1F, B=8'h00 -> cnt=3, hit=0.
- Gaps and reset mid-stream:
  - Pattern in_valid 1,0,1 -> out_valid 1,0,1 after the 2-cycle latency.
  - Assert rst for 1 cycle while 2 samples are in flight -> neither sample appears; out_valid stays 0.
- Stats (XNOR_CORR_STATS_EN defined):
  - 5 consecutive hits -> hit_total=5.
  - clear asserted in the same cycle as hit=1 -> hit_total=0 on the next cycle.
  - 70000 consecutive hits -> hit_total holds at 16'hFFFF.
- Stats compiled out (XNOR_CORR_STATS_EN undefined): repeat the stats scenario.
  - Required: hit_total=0 throughout, and Y, match_cnt, hit, out_valid identical to the enabled build.
